score_digit_loader: RTL and testbench

Sequential nibble demultiplexer: accepts a framed stream of four 4-bit score digits over a valid/ready handshake and distributes them onto four parallel registered digit buses A–D. These buses feed the 4:1 display digit multiplexer. All four outputs update atomically only when a complete frame has been received, so the display never shows a partially written score. It sits between the game/score logic (writer) and the display scan path (reader).

---
 rtl/score_digit_loader_pkg.sv | 20 ++
 rtl/score_digit_loader_frame_timeout.sv | 29 ++
 rtl/score_digit_loader.sv | 139 +++++++++++++
 tb/tb_score_digit_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/score_digit_loader_pkg.sv
// Shared types and constants for the score digit loader: FSM encoding and digit geometry.
package score_digit_loader_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // in_ready is a pure function of the state being entered
    function automatic logic state_ready(input state_t st);
        return (st == ST_LOAD);
    endfunction

endpackage

// File: rtl/score_digit_loader_frame_timeout.sv
// Idle-cycle counter for the loader; tc flags the last tolerated cycle without an accepted digit.
module frame_timeout #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [15:0] count_r;

    // Counter register: clear wins over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 16'd0;
        end else if (clr) begin
            count_r <= 16'd0;
        end else if (en) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == (TIMEOUT_CYCLES - 16'd1));

endmodule

// File: rtl/score_digit_loader.sv
// Collects a framed stream of four score digits and publishes them to A-D atomically on frame completion.
module score_digit_loader
    import score_digit_loader_pkg::*;
#(
    parameter logic [3:0]  RESET_NIBBLE   = 4'h0,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] C,
    output logic [3:0] D,
    output logic       frame_done,
    output logic       frame_err
);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  idx_r;
    logic [1:0]  idx_nxt_s;
    digit_t      shadow_r [NUM_DIGITS];
    logic        accept_s;
    logic        idle_cycle_s;
    logic        tc_s;
    logic        tmr_en_s;
    logic        tmr_clr_s;
    logic        done_nxt_s;
    logic        err_nxt_s;
    logic        in_ready_r;
    logic        frame_done_r;
    logic        frame_err_r;
    digit_t      a_r, b_r, c_r, d_r;

    frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_s),
        .en    (tmr_en_s),
        .tc    (tc_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a restart in LOAD outranks a same-cycle digit
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) state_nxt_s = ST_LOAD;
                else             state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (frame_start)                          state_nxt_s = ST_LOAD;
                else if (in_valid && (idx_r == 2'd3))     state_nxt_s = ST_COMMIT;
                else if (in_valid)                        state_nxt_s = ST_LOAD;
                else if (tc_s)                            state_nxt_s = ST_IDLE;
                else                                      state_nxt_s = ST_LOAD;
            end
            ST_COMMIT: begin
                if (frame_start) state_nxt_s = ST_LOAD;
                else             state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/control decode: accept, timer control, index update, pulse requests
    always_comb begin
        accept_s     = 1'b0;
        idle_cycle_s = 1'b0;
        idx_nxt_s    = 2'd0;
        done_nxt_s   = 1'b0;
        err_nxt_s    = 1'b0;
        if (state_r == ST_LOAD) begin
            accept_s     = in_valid && !frame_start;
            idle_cycle_s = !in_valid && !frame_start;
            err_nxt_s    = frame_start || (idle_cycle_s && tc_s);
            if (accept_s) idx_nxt_s = idx_r + 2'd1;
            else if (frame_start) idx_nxt_s = 2'd0;
            else idx_nxt_s = idx_r;
        end else begin
            done_nxt_s = (state_r == ST_COMMIT);
        end
        tmr_en_s  = idle_cycle_s && !tc_s;
        tmr_clr_s = !tmr_en_s;
    end

    // Index, shadow and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r        <= 2'd0;
            for (int i = 0; i < NUM_DIGITS; i++) shadow_r[i] <= RESET_NIBBLE;
            a_r          <= RESET_NIBBLE;
            b_r          <= RESET_NIBBLE;
            c_r          <= RESET_NIBBLE;
            d_r          <= RESET_NIBBLE;
            in_ready_r   <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            idx_r <= idx_nxt_s;
            if (accept_s) begin
                shadow_r[idx_r] <= in_data;
            end
            if (done_nxt_s) begin
                a_r <= shadow_r[0];
                b_r <= shadow_r[1];
                c_r <= shadow_r[2];
                d_r <= shadow_r[3];
            end
            in_ready_r   <= state_ready(state_nxt_s);
            frame_done_r <= done_nxt_s;
            frame_err_r  <= err_nxt_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;
    assign A          = a_r;
    assign B          = b_r;
    assign C          = c_r;
    assign D          = d_r;

endmodule

// File: tb/tb_score_digit_loader.sv
// Directed bench for score_digit_loader with a scoreboard of expected committed frames.
module tb_score_digit_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_ready;
    logic [3:0] A, B, C, D;
    logic       frame_done;
    logic       frame_err;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int err_seen = 0;
    logic [15:0] sb_q [$];

    score_digit_loader #(
        .RESET_NIBBLE  (4'h0),
        .TIMEOUT_CYCLES(16'd10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; observe on the falling edge and retire any committed frame
    task automatic cyc();
        logic [15:0] exp_v;
        @(posedge clk);
        @(negedge clk);
        if (frame_err) err_seen++;
        if (frame_done) begin
            done_seen++;
            chk("done_err_exclusive", {31'd0, frame_err}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_commit", {16'd0, A, B, C, D}, 32'hFFFF_FFFF);
            end else begin
                exp_v = sb_q.pop_front();
                chk("commit_abcd", {16'd0, A, B, C, D}, {16'd0, exp_v});
            end
        end
    endtask

    task automatic fs_pulse(input logic v, input logic [3:0] d);
        frame_start = 1'b1;
        in_valid = v;
        in_data = d;
        cyc();
        frame_start = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic put(input logic [3:0] d);
        in_valid = 1'b1;
        in_data = d;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int d0, e0, hit;
        // Power-on reset
        repeat (3) @(negedge clk);
        chk("rst_abcd", {16'd0, A, B, C, D}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_done_err", {30'd0, frame_done, frame_err}, 32'd0);
        rst_n = 1'b1;
        idle(2);
        in_valid = 1'b1; in_data = 4'hA;
        cyc();
        in_valid = 1'b0;
        chk("idle_ignores_valid", {15'd0, in_ready, A, B, C, D}, 32'd0);

        // Nominal frame 1,2,3,4
        fs_pulse(1'b0, 4'h0);
        chk("nom_ready_after_start", {31'd0, in_ready}, 32'd1);
        put(4'h1); put(4'h2); put(4'h3);
        chk("nom_hold_while_loading", {16'd0, A, B, C, D}, 32'd0);
        sb_q.push_back(16'h1234);
        d0 = done_seen;
        put(4'h4);
        chk("nom_no_done_at_last_accept", {31'd0, frame_done}, 32'd0);
        chk("nom_hold_at_last_accept", {16'd0, A, B, C, D}, 32'd0);
        chk("nom_ready_low_commit", {31'd0, in_ready}, 32'd0);
        cyc();
        chk("nom_done_latency", done_seen - d0, 32'd1);
        cyc();
        chk("nom_done_one_cycle", {31'd0, frame_done}, 32'd0);

        // Gapped frame 9,F,0,7 with 3 idle cycles between digits
        e0 = err_seen;
        d0 = done_seen;
        fs_pulse(1'b0, 4'h0);
        put(4'h9); idle(3);
        put(4'hF); idle(3);
        put(4'h0); idle(3);
        sb_q.push_back(16'h9F07);
        put(4'h7);
        idle(2);
        chk("gap_committed", done_seen - d0, 32'd1);
        chk("gap_no_err", err_seen - e0, 32'd0);

        // Timeout after two digits: error on the 10th idle cycle
        fs_pulse(1'b0, 4'h0);
        put(4'h5); put(4'h6);
        hit = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (frame_err) begin
                hit = i;
                break;
            end
        end
        chk("timeout_cycle", hit, 32'd10);
        chk("timeout_ready_low", {31'd0, in_ready}, 32'd0);
        chk("timeout_abcd_kept", {16'd0, A, B, C, D}, 32'h9F07);
        cyc();
        chk("timeout_err_one_cycle", {31'd0, frame_err}, 32'd0);

        // Restart after three digits, concurrent digit 5 dropped
        fs_pulse(1'b0, 4'h0);
        put(4'h1); put(4'h1); put(4'h1);
        fs_pulse(1'b1, 4'h5);
        chk("restart_err", {31'd0, frame_err}, 32'd1);
        chk("restart_ready", {31'd0, in_ready}, 32'd1);
        d0 = done_seen;
        put(4'h6); put(4'h7); put(4'h8);
        sb_q.push_back(16'h6789);
        put(4'h9);
        cyc();
        chk("restart_committed", done_seen - d0, 32'd1);

        // Back-to-back frames with frame_start during COMMIT
        e0 = err_seen;
        fs_pulse(1'b0, 4'h0);
        put(4'hA); put(4'hB); put(4'hC);
        sb_q.push_back(16'hABCD);
        put(4'hD);
        d0 = done_seen;
        fs_pulse(1'b0, 4'h0);
        chk("b2b_done", done_seen - d0, 32'd1);
        chk("b2b_ready_next", {31'd0, in_ready}, 32'd1);
        put(4'hE); put(4'hF); put(4'h0);
        sb_q.push_back(16'hEF01);
        put(4'h1);
        cyc();
        chk("b2b_second_committed", done_seen - d0, 32'd2);
        chk("b2b_no_err", err_seen - e0, 32'd0);
        chk("abcd_after_b2b", {16'd0, A, B, C, D}, 32'hEF01);

        // Asynchronous reset mid-LOAD after two digits
        fs_pulse(1'b0, 4'h0);
        put(4'h3); put(4'h4);
        rst_n = 1'b0;
        #1;
        chk("midrst_abcd", {16'd0, A, B, C, D}, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_done", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_seen;
        put(4'h7); put(4'h7);
        idle(3);
        chk("postrst_no_commit", done_seen - d0, 32'd0);
        chk("postrst_idle", {15'd0, in_ready, A, B, C, D}, 32'd0);
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
